// File: rtl/led_seq_pkg.sv
// led_seq_pkg
// Shared types for the LED mode sequencer: display mode encoding, bounce
// direction, and the seed pattern that each mode starts from when loaded.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    function automatic logic [7:0] seed_of(input mode_e m);
        logic [7:0] s;
        case (m)
            MODE_ROTATE: s = 8'h01;
            MODE_BOUNCE: s = 8'h01;
            default:     s = 8'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/led_mode_sequencer_prescaler.sv
// led_prescaler
// Divides clk into a step strobe every MAX_COUNT running cycles.
// Ports:
//   clk   - system clock
//   rst   - synchronous reset, active-high
//   run   - 1 = count, 0 = hold
//   clear - synchronous restart of the count at 0 (used on mode load)
//   step  - combinational strobe, high while running at the terminal count
module led_prescaler #(
    parameter int unsigned MAX_COUNT = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic step
);

    localparam int unsigned CNT_W = $clog2(MAX_COUNT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_COUNT - 1);

    logic [CNT_W-1:0] count;
    logic             at_last;

    assign at_last = (count == LAST);
    assign step    = run & at_last;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (run) begin
            count <= at_last ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_mode_sequencer.sv
// led_mode_sequencer
// Drives the 8 user LEDs with one of four animated patterns. A prescaler
// produces a step every MAX_COUNT running cycles; each step advances the
// pattern according to the active mode. A rising edge on mode_load selects
// mode_req and re-seeds the pattern.
// Ports:
//   clk       - system clock
//   rst       - synchronous reset, active-high
//   run       - 1 = prescaler and pattern advance, 0 = freeze
//   mode_req  - mode captured on a mode_load rising edge
//   mode_load - level input, its rising edge loads a mode
//   leds      - current pattern (registered)
//   mode      - active mode (registered)
//   tick      - one-cycle pulse in the cycle after the pattern advanced
//
// Pattern state:
//   mode  | meaning
//   COUNT | binary up-count, wraps FF -> 00
//   ROTATE| single bit rotates left, 80 -> 01
//   BOUNCE| single bit walks 01..80..01, dir flips at the end bits
//   BLINK | whole byte inverts every step
module led_mode_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned MAX_COUNT = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [1:0] mode_req,
    input  logic       mode_load,
    output logic [7:0] leds,
    output logic [1:0] mode,
    output logic       tick
);

    mode_e      mode_q, mode_d;
    dir_e       dir_q, dir_d;
    logic [7:0] leds_q, leds_d;
    logic       tick_q, tick_d;
    logic       mode_load_q;
    logic       load;
    logic       step;

    assign load = mode_load & ~mode_load_q;

    led_prescaler #(
        .MAX_COUNT(MAX_COUNT)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .clear(load),
        .step (step)
    );

    always_comb begin
        mode_d = mode_q;
        dir_d  = dir_q;
        leds_d = leds_q;
        tick_d = 1'b0;
        if (load) begin
            mode_d = mode_e'(mode_req);
            leds_d = seed_of(mode_e'(mode_req));
            dir_d  = DIR_LEFT;
        end else if (step) begin
            tick_d = 1'b1;
            case (mode_q)
                MODE_COUNT:  leds_d = leds_q + 8'd1;
                MODE_ROTATE: leds_d = {leds_q[6:0], leds_q[7]};
                MODE_BOUNCE: begin
                    // Turn around on reaching an end bit so the endpoints
                    // are shown once rather than twice.
                    if (dir_q == DIR_LEFT) begin
                        leds_d = {leds_q[6:0], 1'b0};
                        if (leds_d == 8'h80) dir_d = DIR_RIGHT;
                    end else begin
                        leds_d = {1'b0, leds_q[7:1]};
                        if (leds_d == 8'h01) dir_d = DIR_LEFT;
                    end
                end
                MODE_BLINK:  leds_d = ~leds_q;
                default:     leds_d = leds_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= MODE_COUNT;
            dir_q       <= DIR_LEFT;
            leds_q      <= 8'h00;
            tick_q      <= 1'b0;
            mode_load_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            dir_q       <= dir_d;
            leds_q      <= leds_d;
            tick_q      <= tick_d;
            mode_load_q <= mode_load;
        end
    end

    assign leds = leds_q;
    assign mode = mode_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
module tb_led_mode_sequencer;

    localparam int unsigned MC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [1:0] mode_req;
    logic       mode_load;
    logic [7:0] leds;
    logic [1:0] mode;
    logic       tick;

    int total = 0;
    int bad   = 0;
    logic [7:0] cur;

    typedef struct {
        logic       run;
        logic [1:0] mreq;
        logic       mload;
        logic [7:0] leds;
        logic [1:0] mode;
        logic       tick;
    } vec_t;

    vec_t tbl[20];
    logic [7:0] rot_exp[8];
    logic [7:0] bnc_exp[16];

    led_mode_sequencer #(.MAX_COUNT(MC)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .mode_req (mode_req),
        .mode_load(mode_load),
        .leds     (leds),
        .mode     (mode),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string nm, input logic [7:0] el,
                             input logic [1:0] em, input logic et);
        chk({nm, ".leds"}, leds, el);
        chk({nm, ".mode"}, {6'd0, mode}, {6'd0, em});
        chk({nm, ".tick"}, {7'd0, tick}, {7'd0, et});
    endtask

    task automatic cyc(input logic r, input logic rn, input logic [1:0] mr, input logic ml);
        rst       = r;
        run       = rn;
        mode_req  = mr;
        mode_load = ml;
        @(posedge clk);
        #1;
    endtask

    // Three quiet cycles followed by one step cycle that must show exp.
    task automatic advance(input string nm, input logic [7:0] exp, input logic [1:0] em,
                           input logic [1:0] mr, input logic ml);
        for (int k = 0; k < MC - 1; k++) begin
            cyc(1'b0, 1'b1, mr, ml);
            check_out({nm, ".idle"}, cur, em, 1'b0);
        end
        cyc(1'b0, 1'b1, mr, ml);
        check_out({nm, ".step"}, exp, em, 1'b1);
        cur = exp;
    endtask

    initial begin
        //             run mreq mload leds   mode tick
        tbl[0]  = '{1'b1, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0};
        tbl[1]  = '{1'b1, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0};
        tbl[3]  = '{1'b1, 2'd0, 1'b0, 8'h01, 2'd0, 1'b1};
        tbl[4]  = '{1'b1, 2'd0, 1'b0, 8'h01, 2'd0, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 1'b0, 8'h01, 2'd0, 1'b0};
        tbl[6]  = '{1'b0, 2'd0, 1'b0, 8'h01, 2'd0, 1'b0};
        tbl[7]  = '{1'b1, 2'd0, 1'b0, 8'h01, 2'd0, 1'b0};
        tbl[8]  = '{1'b1, 2'd0, 1'b0, 8'h01, 2'd0, 1'b0};
        tbl[9]  = '{1'b1, 2'd0, 1'b0, 8'h02, 2'd0, 1'b1};
        tbl[10] = '{1'b1, 2'd1, 1'b1, 8'h01, 2'd1, 1'b0};
        tbl[11] = '{1'b1, 2'd1, 1'b1, 8'h01, 2'd1, 1'b0};
        tbl[12] = '{1'b1, 2'd1, 1'b0, 8'h01, 2'd1, 1'b0};
        tbl[13] = '{1'b1, 2'd1, 1'b0, 8'h01, 2'd1, 1'b0};
        tbl[14] = '{1'b1, 2'd1, 1'b0, 8'h02, 2'd1, 1'b1};
        tbl[15] = '{1'b0, 2'd3, 1'b1, 8'h00, 2'd3, 1'b0};
        tbl[16] = '{1'b1, 2'd3, 1'b1, 8'h00, 2'd3, 1'b0};
        tbl[17] = '{1'b1, 2'd3, 1'b1, 8'h00, 2'd3, 1'b0};
        tbl[18] = '{1'b1, 2'd3, 1'b1, 8'h00, 2'd3, 1'b0};
        tbl[19] = '{1'b1, 2'd3, 1'b1, 8'hFF, 2'd3, 1'b1};

        rot_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        bnc_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                    8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

        // Reset state
        cyc(1'b1, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 1'b1, 2'd2, 1'b0);
        check_out("reset", 8'h00, 2'd0, 1'b0);

        // Table-driven vectors
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, tbl[i].run, tbl[i].mreq, tbl[i].mload);
            check_out($sformatf("vec%0d", i), tbl[i].leds, tbl[i].mode, tbl[i].tick);
        end

        // Free-running COUNT from reset: 10 ticks in 40 cycles
        cyc(1'b1, 1'b1, 2'd0, 1'b0);
        check_out("count.reset", 8'h00, 2'd0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 1'b1, 2'd0, 1'b0);
            check_out($sformatf("count.c%0d", i), 8'((i + 1) / 4), 2'd0,
                      ((i + 1) % 4) == 0);
        end
        chk("count.after10", leds, 8'h0A);

        // COUNT wrap through FF -> 00, mode_load held high throughout
        cyc(1'b0, 1'b1, 2'd0, 1'b1);
        check_out("wrap.load", 8'h00, 2'd0, 1'b0);
        cur = 8'h00;
        for (int i = 1; i <= 256; i++)
            advance($sformatf("wrap.t%0d", i), 8'(i), 2'd0, 2'd0, 1'b1);
        chk("wrap.final", leds, 8'h00);

        // ROTATE
        cyc(1'b0, 1'b1, 2'd1, 1'b0);
        cyc(1'b0, 1'b1, 2'd1, 1'b1);
        check_out("rot.load", 8'h01, 2'd1, 1'b0);
        cur = 8'h01;
        for (int i = 0; i < 8; i++)
            advance($sformatf("rot.t%0d", i), rot_exp[i], 2'd1, 2'd1, 1'b0);

        // BOUNCE, then freeze with run=0
        cyc(1'b0, 1'b1, 2'd2, 1'b1);
        check_out("bnc.load", 8'h01, 2'd2, 1'b0);
        cur = 8'h01;
        for (int i = 0; i < 16; i++)
            advance($sformatf("bnc.t%0d", i), bnc_exp[i], 2'd2, 2'd2, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 2'd2, 1'b0);
            check_out($sformatf("freeze.c%0d", i), 8'h04, 2'd2, 1'b0);
        end

        // BLINK, then load colliding with a step
        cyc(1'b0, 1'b1, 2'd3, 1'b1);
        check_out("blink.load", 8'h00, 2'd3, 1'b0);
        cur = 8'h00;
        advance("blink.t0", 8'hFF, 2'd3, 2'd3, 1'b0);
        advance("blink.t1", 8'h00, 2'd3, 2'd3, 1'b0);
        for (int i = 0; i < MC - 1; i++) begin
            cyc(1'b0, 1'b1, 2'd3, 1'b0);
            check_out("coll.pre", 8'h00, 2'd3, 1'b0);
        end
        cyc(1'b0, 1'b1, 2'd1, 1'b1);
        check_out("coll.load", 8'h01, 2'd1, 1'b0);
        cur = 8'h01;
        advance("coll.t0", 8'h02, 2'd1, 2'd1, 1'b1);
        advance("coll.t1", 8'h04, 2'd1, 2'd1, 1'b1);
        cyc(1'b0, 1'b1, 2'd1, 1'b1);
        check_out("hold.c0", 8'h04, 2'd1, 1'b0);
        cyc(1'b0, 1'b1, 2'd1, 1'b1);
        check_out("hold.c1", 8'h04, 2'd1, 1'b0);

        // Reset mid-BOUNCE while heading right at 8'h20
        cyc(1'b0, 1'b1, 2'd2, 1'b0);
        cyc(1'b0, 1'b1, 2'd2, 1'b1);
        check_out("rb.load", 8'h01, 2'd2, 1'b0);
        cur = 8'h01;
        for (int i = 0; i < 9; i++)
            advance($sformatf("rb.t%0d", i), bnc_exp[i], 2'd2, 2'd2, 1'b0);
        chk("rb.at20", leds, 8'h20);
        for (int i = 0; i < MC - 1; i++)
            cyc(1'b0, 1'b1, 2'd2, 1'b0);
        cyc(1'b1, 1'b1, 2'd2, 1'b1);
        check_out("rb.reset", 8'h00, 2'd0, 1'b0);
        cur = 8'h00;
        advance("rb.first", 8'h01, 2'd0, 2'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
